// File: rtl/ipsxe_floating_point_rom_seq_ctrl.sv
// Operand-ROM stimulus sequencer for the floating-point example design: reads each ROM word, hands it to the core,
// folds every result into a rotate-XOR signature. Define IPSXE_FLT_ROM_SEQ_LOOP_EN to repeat passes until timeout/reset.
module ipsxe_floating_point_rom_seq_ctrl #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int NUM_VEC   = 4,
    parameter int TO_CYCLES = 255,
    localparam int W = 1 + EXP_WIDTH + MAN_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [3:0]   rom_rd_addr,
    input  logic [W-1:0] rom_dout,
    output logic [W-1:0] op_tdata,
    output logic         op_tvalid,
    input  logic         op_tready,
    input  logic [W-1:0] res_tdata,
    input  logic         res_tvalid,
    output logic         busy,
    output logic         done,
    output logic         timeout_err,
    output logic [4:0]   vec_cnt,
    output logic [W-1:0] signature,
    output logic [7:0]   loop_cnt
);

`ifdef IPSXE_FLT_ROM_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam logic [3:0]  LAST_IDX = 4'(NUM_VEC - 1);
    localparam logic [15:0] TMR_LOAD = 16'(TO_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_LOAD     = 3'd2,
        ST_SEND     = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [15:0] tmr;
    logic        start_acc;
    logic        hs;
    logic        res_acc;
    logic        tmo;
    logic        last_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        hs        = 1'b0;
        res_acc   = 1'b0;
        tmo       = 1'b0;
        last_vec  = (idx == LAST_IDX);
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = ST_RD;
                end
            end
            ST_RD:   state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_SEND;
            // A handshake or result in the terminal-count cycle takes priority over the timeout.
            ST_SEND: begin
                if (op_tvalid && op_tready) begin
                    hs        = 1'b1;
                    state_nxt = ST_WAIT_RES;
                end else if (tmr == 16'd0) begin
                    tmo       = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_WAIT_RES: begin
                if (res_tvalid) begin
                    res_acc   = 1'b1;
                    state_nxt = (last_vec && !LOOP_EN) ? ST_DONE : ST_RD;
                end else if (tmr == 16'd0) begin
                    tmo       = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= 4'd0;
            tmr         <= 16'd0;
            op_tdata    <= '0;
            op_tvalid   <= 1'b0;
            timeout_err <= 1'b0;
            vec_cnt     <= 5'd0;
            signature   <= '0;
            loop_cnt    <= 8'd0;
        end else begin
            if (start_acc) begin
                idx         <= 4'd0;
                vec_cnt     <= 5'd0;
                signature   <= '0;
                timeout_err <= 1'b0;
                loop_cnt    <= 8'd0;
            end
            if (state == ST_LOAD) begin
                op_tdata  <= rom_dout;
                op_tvalid <= 1'b1;
            end
            if (hs) op_tvalid <= 1'b0;
            if (tmo) begin
                op_tvalid   <= 1'b0;
                timeout_err <= 1'b1;
            end
            if (res_acc) begin
                signature <= {signature[W-2:0], signature[W-1]} ^ res_tdata;
                vec_cnt   <= vec_cnt + 5'd1;
                if (!last_vec) begin
                    idx <= idx + 4'd1;
                end else if (LOOP_EN) begin
                    idx <= 4'd0;
                    if (loop_cnt != 8'hFF) loop_cnt <= loop_cnt + 8'd1;
                end
            end
            // Down-counter reloaded on entry to SEND and WAIT_RES; zero marks the last allowed cycle.
            if (state == ST_LOAD || hs)
                tmr <= TMR_LOAD;
            else if ((state == ST_SEND || state == ST_WAIT_RES) && tmr != 16'd0)
                tmr <= tmr - 16'd1;
        end
    end

    assign rom_rd_addr = idx;
    assign busy        = (state != ST_IDLE) && (state != ST_DONE);
    assign done        = (state == ST_DONE);

endmodule

// File: tb/tb_ipsxe_floating_point_rom_seq_ctrl.sv
// Bench for ipsxe_floating_point_rom_seq_ctrl with a behavioural ROM and floating-point core stand-in.
// The loop scenario is built when IPSXE_FLT_ROM_SEQ_LOOP_EN is defined.
`timescale 1ns/1ps
module tb_ipsxe_floating_point_rom_seq_ctrl;
    localparam int W         = 32;
    localparam int NUM_VEC   = 4;
    localparam int TO_CYCLES = 255;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   rom_rd_addr;
    logic [W-1:0] rom_dout;
    logic [W-1:0] op_tdata;
    logic         op_tvalid;
    logic         op_tready;
    logic [W-1:0] res_tdata;
    logic         res_tvalid;
    logic         busy;
    logic         done;
    logic         timeout_err;
    logic [4:0]   vec_cnt;
    logic [W-1:0] signature;
    logic [7:0]   loop_cnt;

    ipsxe_floating_point_rom_seq_ctrl #(
        .EXP_WIDTH (8),
        .MAN_WIDTH (23),
        .NUM_VEC   (NUM_VEC),
        .TO_CYCLES (TO_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rom_rd_addr (rom_rd_addr),
        .rom_dout    (rom_dout),
        .op_tdata    (op_tdata),
        .op_tvalid   (op_tvalid),
        .op_tready   (op_tready),
        .res_tdata   (res_tdata),
        .res_tvalid  (res_tvalid),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .vec_cnt     (vec_cnt),
        .signature   (signature),
        .loop_cnt    (loop_cnt)
    );

    always #5 clk = ~clk;

    logic [W-1:0] rom [16];
    always @(posedge clk) rom_dout <= rom[rom_rd_addr];

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus knobs, written by the main sequence only
    int           ready_mode;
    int           lat_fixed;
    bit           lat_rand;
    bit           stray_en;
    int           drop_vec;
    logic [W-1:0] res_key;

    // core stand-in state, written by the core process only
    longint       cyc;
    longint       hs_cyc;
    longint       to_cyc;
    bit           to_seen;
    int           pend;
    int           hs_num;
    int           stall_cnt;
    int           wraps;
    int           stable_viol;
    bit           outstanding;
    bit           prev_wait;
    logic [W-1:0] pend_data;
    logic [W-1:0] prev_data;
    logic [3:0]   prev_addr;
    logic [W-1:0] op_log [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc         = 0;
            hs_cyc      = 0;
            to_cyc      = 0;
            to_seen     = 1'b0;
            pend        = 0;
            hs_num      = 0;
            stall_cnt   = 0;
            wraps       = 0;
            stable_viol = 0;
            outstanding = 1'b0;
            prev_wait   = 1'b0;
            prev_addr   = 4'd0;
            op_tready   = 1'b0;
            res_tvalid  = 1'b0;
            res_tdata   = '0;
            op_log.delete();
        end else begin
            cyc = cyc + 1;
            if (timeout_err && !to_seen) begin
                to_seen = 1'b1;
                to_cyc  = cyc;
            end
            if (prev_wait && !timeout_err && (!op_tvalid || op_tdata !== prev_data))
                stable_viol++;
            if (busy && prev_addr == 4'(NUM_VEC - 1) && rom_rd_addr == 4'd0)
                wraps++;
            prev_addr  = rom_rd_addr;
            res_tvalid = 1'b0;
            res_tdata  = '0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    res_tvalid  = 1'b1;
                    res_tdata   = pend_data;
                    outstanding = 1'b0;
                end
            end else if (stray_en && !outstanding && $urandom_range(3, 0) == 0) begin
                res_tvalid = 1'b1;
                res_tdata  = $urandom;
            end
            case (ready_mode)
                0: op_tready = 1'b1;
                1: op_tready = ($urandom_range(2, 0) != 0);
                default: begin
                    if (op_tvalid && hs_num == 1 && stall_cnt < 3) begin
                        op_tready = 1'b0;
                        stall_cnt++;
                    end else begin
                        op_tready = 1'b1;
                    end
                end
            endcase
            if (op_tvalid && op_tready) begin
                hs_cyc      = cyc;
                outstanding = 1'b1;
                op_log.push_back(op_tdata);
                if (hs_num != drop_vec) begin
                    pend      = lat_rand ? int'($urandom_range(4, 1)) : lat_fixed;
                    pend_data = op_tdata ^ res_key;
                end
                hs_num++;
            end
            prev_wait = op_tvalid && !op_tready;
            prev_data = op_tdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // rotate-left-by-one then XOR, folded over the result stream
    function automatic logic [W-1:0] sig_of(input logic [W-1:0] res [$]);
        logic [W-1:0] s;
        s = '0;
        foreach (res[i]) s = ((s << 1) | (s >> (W - 1))) ^ res[i];
        return s;
    endfunction

    task automatic do_reset();
        start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rom_rd_addr"}, rom_rd_addr, 0);
        chk({tag, "_op_tdata"},    op_tdata, 0);
        chk({tag, "_op_tvalid"},   op_tvalid, 0);
        chk({tag, "_busy"},        busy, 0);
        chk({tag, "_done"},        done, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_vec_cnt"},     vec_cnt, 0);
        chk({tag, "_signature"},   signature, 0);
        chk({tag, "_loop_cnt"},    loop_cnt, 0);
    endtask

    task automatic wait_done(input string tag, input int budget, input bit poke_start);
        int n;
        n = 0;
        while (!done && n < budget) begin
            start = poke_start && busy && ($urandom_range(2, 0) == 0);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, "_reached_done"}, done, 1);
    endtask

    task automatic run_to_done(input string tag, input bit poke_start);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(tag, 2000, poke_start);
    endtask

    task automatic check_pass(input string tag, input int n_res, input int n_xfer, input bit exp_to);
        logic [W-1:0] res [$];
        for (int i = 0; i < n_res; i++) res.push_back(rom[i] ^ res_key);
        chk({tag, "_xfers"}, op_log.size(), n_xfer);
        for (int i = 0; i < n_xfer && i < op_log.size(); i++)
            chk($sformatf("%s_operand%0d", tag, i), op_log[i], rom[i]);
        chk({tag, "_signature"},   signature, sig_of(res));
        chk({tag, "_vec_cnt"},     vec_cnt, n_res);
        chk({tag, "_done"},        done, 1);
        chk({tag, "_busy"},        busy, 0);
        chk({tag, "_timeout_err"}, timeout_err, exp_to);
        chk({tag, "_loop_cnt"},    loop_cnt, 0);
        chk({tag, "_op_stable"},   stable_viol, 0);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        ready_mode = 0;
        lat_fixed  = 2;
        lat_rand   = 1'b0;
        stray_en   = 1'b0;
        drop_vec   = -1;
        res_key    = '0;
        for (int i = 0; i < 16; i++) rom[i] = $urandom;
        rom[0] = 32'h40800000;
        rom[1] = 32'h7FC00000;
        rom[2] = 32'h7F800000;
        rom[3] = 32'h00000000;

        do_reset();
        chk_all_zero("reset");

`ifdef IPSXE_FLT_ROM_SEQ_LOOP_EN
        begin
            logic [W-1:0] res [$];
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (vec_cnt != 5'd8 && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("loop_vec_cnt", vec_cnt, 8);
            @(negedge clk);
            for (int i = 0; i < 8; i++) res.push_back(rom[i % NUM_VEC]);
            chk("loop_cnt", loop_cnt, 2);
            chk("loop_done", done, 0);
            chk("loop_busy", busy, 1);
            chk("loop_wraps", wraps, 2);
            chk("loop_signature", signature, sig_of(res));
            chk("loop_timeout_err", timeout_err, 0);
            do_reset();
            chk_all_zero("loop_reset");
        end
`else
        // echo core, ready always high, first-operand timing
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_valid_rd", op_tvalid, 0);
        @(negedge clk);
        chk("t1_valid_load", op_tvalid, 0);
        @(negedge clk);
        chk("t1_valid_send", op_tvalid, 1);
        chk("t1_first_op", op_tdata, 32'h40800000);
        wait_done("t1", 2000, 1'b0);
        check_pass("t1", 4, 4, 1'b0);
        chk("t1_sig_const", signature, 32'h04000003);

        // operand held through a 3-cycle stall on vector 1
        do_reset();
        ready_mode = 2;
        run_to_done("t2", 1'b0);
        check_pass("t2", 4, 4, 1'b0);
        chk("t2_stall_cycles", stall_cnt, 3);
        chk("t2_sig_const", signature, 32'h04000003);
        ready_mode = 0;

        // core drops vector 2
        do_reset();
        drop_vec = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!timeout_err && n < 600) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("t3_flag", timeout_err, 1);
        chk("t3_latency", to_cyc - hs_cyc - 1, TO_CYCLES);
        chk("t3_op_tvalid", op_tvalid, 0);
        check_pass("t3", 2, 3, 1'b1);
        drop_vec = -1;

        // start pulses while busy, stray results outside WAIT_RES
        do_reset();
        stray_en = 1'b1;
        run_to_done("t4", 1'b1);
        repeat (20) @(negedge clk);
        chk("t4_no_restart", hs_num, 4);
        check_pass("t4", 4, 4, 1'b0);
        chk("t4_sig_const", signature, 32'h04000003);
        stray_en = 1'b0;

        // reset while waiting for the result of vector 1
        do_reset();
        lat_fixed = 6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (hs_num < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("t5_mid_vec_cnt", vec_cnt, 1);
        chk("t5_mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lat_fixed = 2;
        run_to_done("t5", 1'b0);
        check_pass("t5", 4, 4, 1'b0);
        chk("t5_sig_const", signature, 32'h04000003);

        // randomized ROM contents, result transform, back-pressure and latency
        for (int r = 0; r < 12; r++) begin
            do_reset();
            for (int i = 0; i < 16; i++) rom[i] = $urandom;
            res_key    = $urandom;
            ready_mode = 1;
            lat_rand   = 1'b1;
            stray_en   = 1'b1;
            run_to_done("rnd", 1'b1);
            check_pass($sformatf("rnd%0d", r), 4, 4, 1'b0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
